// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard inputs and stage enable/clear controls of the pipeline sequencer
interface pipe_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    logic [4:0]        rs1_d;
    logic [4:0]        rs2_d;
    logic [4:0]        rd_e;
    logic              mem_read_e;
    logic              pc_src_e;
    logic              mem_req_m;
    logic              mem_ready;
    logic              err_clr;
    logic              en_pc;
    logic              en_fd;
    logic              clr_fd;
    logic              en_de;
    logic              clr_de;
    logic              en_em;
    logic              clr_em;
    logic              en_mw;
    logic              clr_mw;
    logic              mem_err;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mem_req_m, mem_ready, err_clr,
        input  en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
        input  mem_err, stall_cnt
    );

    modport slave (
        input  rs1_d, rs2_d, rd_e, mem_read_e, pc_src_e, mem_req_m, mem_ready, err_clr,
        output en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
        output mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/flush/memory-wait sequencer for the 5-stage pipeline registers
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_nxt;
    logic              err_q, err_nxt;
    logic [PERF_W-1:0] stall_q;
    logic              mem_stall;
    logic              lu;

    assign mem_stall = bus.mem_req_m & ~bus.mem_ready;
    assign lu        = bus.mem_read_e & (bus.rd_e != 5'd0) &
                       ((bus.rd_e == bus.rs1_d) | (bus.rd_e == bus.rs2_d));

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        err_nxt    = err_q;
        bus.en_pc  = 1'b1;
        bus.en_fd  = 1'b1;
        bus.en_de  = 1'b1;
        bus.en_em  = 1'b1;
        bus.en_mw  = 1'b1;
        bus.clr_fd = 1'b0;
        bus.clr_de = 1'b0;
        bus.clr_em = 1'b0;
        bus.clr_mw = 1'b0;

        // A frozen pipeline (mem wait, timeout, error) drops every enable at once.
        if ((state == RUN && mem_stall) ||
            (state == MEM_WAIT && !bus.mem_ready) ||
            (state == ERR)) begin
            bus.en_pc = 1'b0;
            bus.en_fd = 1'b0;
            bus.en_de = 1'b0;
            bus.en_em = 1'b0;
            bus.en_mw = 1'b0;
        end else if (bus.pc_src_e) begin
            bus.clr_fd = 1'b1;
            bus.clr_de = 1'b1;
        end else if (lu) begin
            bus.en_pc  = 1'b0;
            bus.en_fd  = 1'b0;
            bus.clr_de = 1'b1;
        end

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt < WAIT_LIM) begin
                    wait_nxt = wait_cnt + CNT_W'(1);
                end else begin
                    bus.clr_mw = 1'b1;
                    state_nxt  = ERR;
                    err_nxt    = 1'b1;
                end
            end
            ERR: begin
                if (bus.err_clr) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            err_q    <= err_nxt;
        end
    end

    // Saturating so long-running perf sampling never sees a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!bus.en_pc && stall_q != {PERF_W{1'b1}}) begin
            stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign bus.mem_err   = err_q;
    assign bus.stall_cnt = stall_q;
endmodule
